// File: rtl/y86_retire_monitor.sv
// y86_retire_monitor
//
// Architectural retirement monitor for the Y86-64 pipeline, placed beside the
// register file after the write-back stage. It shadows the architectural
// register file, counts cycles / retirements / stalls / bubbles, and runs a
// run -> halt / fault / timeout state machine with a cycle watchdog.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   W_stat, W_icode          W-stage status (AOK/HLT/ADR/INS) and icode
//   W_dstE, W_dstM           W-stage destinations (4'hF = none)
//   W_valE, W_valM           W-stage write-back values
//   W_stall                  W register stalled this cycle
//   F_stall, D_stall         fetch / decode stall indications
//   D_bubble, E_bubble, M_bubble  bubble injections
//   dbg_sel / dbg_rdata      shadow-register read port (1-cycle latency)
//   state, done, final_stat  termination status
//   cycle_cnt, retire_cnt, fstall_cnt, dstall_cnt, bubble_cnt  counters
module y86_retire_monitor #(
   parameter int CW         = 32,
   parameter int MAX_CYCLES = 10000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    W_stat,
   input  logic [3:0]    W_icode,
   input  logic [3:0]    W_dstE,
   input  logic [3:0]    W_dstM,
   input  logic [63:0]   W_valE,
   input  logic [63:0]   W_valM,
   input  logic          W_stall,
   input  logic          F_stall,
   input  logic          D_stall,
   input  logic          D_bubble,
   input  logic          E_bubble,
   input  logic          M_bubble,
   input  logic [3:0]    dbg_sel,
   output logic [63:0]   dbg_rdata,
   output logic [1:0]    state,
   output logic          done,
   output logic [1:0]    final_stat,
   output logic [CW-1:0] cycle_cnt,
   output logic [CW-1:0] retire_cnt,
   output logic [CW-1:0] fstall_cnt,
   output logic [CW-1:0] dstall_cnt,
   output logic [CW-1:0] bubble_cnt
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_HALT    = 2'b01,
      ST_FAULT   = 2'b10,
      ST_TIMEOUT = 2'b11
   } state_e;

   localparam logic [1:0] STAT_AOK  = 2'b00;
   localparam logic [1:0] STAT_HLT  = 2'b01;
   localparam logic [3:0] REG_NONE  = 4'hF;
   localparam logic [3:0] ICODE_NOP = 4'h1;
   localparam logic [CW:0] MAX_W    = (CW+1)'(MAX_CYCLES);

   // Counter slots
   localparam int C_CYC = 0;
   localparam int C_RET = 1;
   localparam int C_FST = 2;
   localparam int C_DST = 3;
   localparam int C_BUB = 4;

   state_e        state_q;
   logic          done_q;
   logic [1:0]    final_stat_q;
   logic [63:0]   shadow_q [0:15];
   logic [63:0]   dbg_rdata_q;
   logic [63:0]   dbg_rdata_d;
   logic [CW-1:0] cnt_q [0:4];
   logic [4:0]    cnt_inc;

   logic          running;
   logic          commit;
   logic [CW:0]   cyc_plus1;
   logic          at_limit;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
      if (en && (v != {CW{1'b1}}))
         return v + {{(CW-1){1'b0}}, 1'b1};
      return v;
   endfunction

   assign running   = (state_q == ST_RUN);
   assign commit    = running & ~W_stall & (W_stat == STAT_AOK);
   // One bit wider so a saturated count cannot wrap into a false match.
   assign cyc_plus1 = {1'b0, cnt_q[C_CYC]} + {{CW{1'b0}}, 1'b1};
   assign at_limit  = (cyc_plus1 == MAX_W);

   // Termination FSM. Status-driven exits wait for an unstalled W entry;
   // the watchdog fires regardless of stall. Terminal states are absorbing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         done_q       <= 1'b0;
         final_stat_q <= 2'b00;
      end else if (running) begin
         if (~W_stall && (W_stat == STAT_HLT)) begin
            state_q      <= ST_HALT;
            done_q       <= 1'b1;
            final_stat_q <= W_stat;
         end else if (~W_stall && W_stat[1]) begin   // ADR or INS
            state_q      <= ST_FAULT;
            done_q       <= 1'b1;
            final_stat_q <= W_stat;
         end else if (at_limit) begin
            state_q      <= ST_TIMEOUT;
            done_q       <= 1'b1;
            final_stat_q <= W_stat;
         end
      end
   end

   // Shadow register file. Entry 15 is never writable and stays zero, which
   // makes "read index 15" return 0 without a special case on the read side.
   // The M-port write takes priority when both ports target the same entry.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_shadow
         localparam logic [3:0] IDX      = 4'(gi);
         localparam bit         WRITABLE = (IDX != REG_NONE);
         always_ff @(posedge clk) begin
            if (rst)
               shadow_q[gi] <= '0;
            else if (WRITABLE && commit && (W_dstM == IDX))
               shadow_q[gi] <= W_valM;
            else if (WRITABLE && commit && (W_dstE == IDX))
               shadow_q[gi] <= W_valE;
         end
      end
   endgenerate

   // Debug read with write-first bypass of a same-edge commit.
   always_comb begin
      dbg_rdata_d = shadow_q[dbg_sel];
      if (dbg_sel != REG_NONE) begin
         if (commit && (W_dstM == dbg_sel))
            dbg_rdata_d = W_valM;
         else if (commit && (W_dstE == dbg_sel))
            dbg_rdata_d = W_valE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         dbg_rdata_q <= '0;
      else
         dbg_rdata_q <= dbg_rdata_d;
   end

   // Performance counters: all frozen outside RUN, all saturating.
   assign cnt_inc[C_CYC] = running;
   assign cnt_inc[C_RET] = commit & (W_icode != ICODE_NOP);
   assign cnt_inc[C_FST] = running & F_stall;
   assign cnt_inc[C_DST] = running & D_stall;
   assign cnt_inc[C_BUB] = running & (D_bubble | E_bubble | M_bubble);

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (rst)
               cnt_q[gi] <= '0;
            else
               cnt_q[gi] <= sat_inc(cnt_q[gi], cnt_inc[gi]);
         end
      end
   endgenerate

   assign dbg_rdata  = dbg_rdata_q;
   assign state      = state_q;
   assign done       = done_q;
   assign final_stat = final_stat_q;
   assign cycle_cnt  = cnt_q[C_CYC];
   assign retire_cnt = cnt_q[C_RET];
   assign fstall_cnt = cnt_q[C_FST];
   assign dstall_cnt = cnt_q[C_DST];
   assign bubble_cnt = cnt_q[C_BUB];

endmodule
